// File: rtl/mcoi_xu5_system_core_pkg.sv
// Shared definitions for the MCOI XU5 system core: motor word layouts,
// control-register bit positions, serial FSM state types and the
// channel-0 page multiplexer.
package mcoi_xu5_system_core_pkg;

  localparam int NUMBER_OF_MOTORS_PER_FIBER = 16;

  // Control register bits (channel 0)
  localparam int LOOPBACK = 31;
  localparam int MOTOREN  = 30;

  // Uplink nibble per motor, MSB first
  typedef struct packed {
    logic       OH_i;
    logic       StepPFail_i;
    logic [1:0] RawSwitches_b2;
  } mcinput_t;

  // Downlink nibble per motor, MSB first
  typedef struct packed {
    logic Boost;
    logic Dir;
    logic En;
    logic Clk;
  } mcoutput_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

  // Word returned on channel 0, selected by Ctrl[3:0]
  function automatic logic [31:0] page_word(input logic [31:0] ctrl,
                                            input logic [31:0] ch1,
                                            input logic [30:0] build);
    logic [31:0] w;
    w = '0;
    case (ctrl[3:0])
      4'd0:    w = {ctrl[LOOPBACK:MOTOREN], build[29:0]};
      4'd1:    w = ch1;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mcoi_xu5_system_core_if.sv
// GBT frame interface of the system core.
//   GbtRxMotor_ib64 / GbtRxSc_ib2 : downlink motor word and SC serial bits
//   GbtTxMotor_ob64 / GbtTxSc_ob2 : uplink motor word and SC serial bits
// master = GBT link side, slave = system core.
interface mcoi_xu5_system_core_if;
  logic [63:0] GbtRxMotor_ib64;
  logic [1:0]  GbtRxSc_ib2;
  logic [63:0] GbtTxMotor_ob64;
  logic [1:0]  GbtTxSc_ob2;

  modport master (
    output GbtRxMotor_ib64, GbtRxSc_ib2,
    input  GbtTxMotor_ob64, GbtTxSc_ob2
  );

  modport slave (
    input  GbtRxMotor_ib64, GbtRxSc_ib2,
    output GbtTxMotor_ob64, GbtTxSc_ob2
  );
endinterface

// File: rtl/mcoi_xu5_system_core_serial_register.sv
// 32-bit serial slow-control register, one bit per frame-clock cycle.
// Frame: idle 1, start 0, 32 data bits MSB first, stop 1.
//   Clk_ik, Rst_irn : frame clock, async active-low reset
//   data_ib32       : word to transmit (resent on change or on keep-alive)
//   data_ob32       : last word received in a valid frame
//   Tx_o, Rx_i      : serial line out / in
//   RxLocked_o      : two consecutive valid frames seen, none missed since
//   TxBusy_o        : high from start bit to stop bit
//
// TX states
//   state    | meaning
//   TX_IDLE  | line high, waiting for changed data or keep-alive expiry
//   TX_START | start bit (0)
//   TX_DATA  | 32 data bits, MSB first
//   TX_STOP  | stop bit (1)
// RX states
//   state    | meaning
//   RX_IDLE  | waiting for a low start bit
//   RX_DATA  | shifting in 32 data bits
//   RX_STOP  | sampling stop bit; 1 = accept frame, 0 = drop and unlock
module mcoi_xu5_system_core_serial_register
  import mcoi_xu5_system_core_pkg::*;
#(
  parameter int g_KeepAlive   = 256,
  parameter int g_LockTimeout = 1024
) (
  input  logic        Clk_ik,
  input  logic        Rst_irn,
  input  logic [31:0] data_ib32,
  output logic [31:0] data_ob32,
  output logic        Tx_o,
  input  logic        Rx_i,
  output logic        RxLocked_o,
  output logic        TxBusy_o
);

  localparam int KA_W = $clog2(g_KeepAlive + 1);
  localparam int TO_W = $clog2(g_LockTimeout + 1);
  localparam logic [KA_W-1:0] KA_RELOAD = KA_W'(g_KeepAlive - 1);
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(g_LockTimeout - 1);

  // ---------------- transmitter ----------------
  tx_state_t       tx_state, tx_next;
  logic [31:0]     tx_shreg;
  logic [31:0]     last_sent;
  logic [4:0]      tx_cnt;
  logic [KA_W-1:0] ka_cnt;
  logic            tx_send;

  // Keep-alive counter starts expired so a frame goes out right after reset
  assign tx_send = (data_ib32 != last_sent) || (ka_cnt == '0);

  always_comb begin
    tx_next  = tx_state;
    Tx_o     = 1'b1;
    TxBusy_o = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        TxBusy_o = 1'b0;
        if (tx_send) tx_next = TX_START;
      end
      TX_START: begin
        Tx_o    = 1'b0;
        tx_next = TX_DATA;
      end
      TX_DATA: begin
        Tx_o = tx_shreg[31];
        if (tx_cnt == 5'd0) tx_next = TX_STOP;
      end
      TX_STOP: tx_next = TX_IDLE;
      default: begin
        TxBusy_o = 1'b0;
        tx_next  = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      tx_state  <= TX_IDLE;
      tx_shreg  <= '0;
      last_sent <= '0;
      tx_cnt    <= '0;
      ka_cnt    <= '0;
    end else begin
      tx_state <= tx_next;
      // Data is captured only at frame start; later changes wait for the next frame
      if (tx_state == TX_IDLE && tx_send) begin
        tx_shreg  <= data_ib32;
        last_sent <= data_ib32;
        ka_cnt    <= KA_RELOAD;
      end else if (ka_cnt != '0) begin
        ka_cnt <= ka_cnt - 1'b1;
      end
      if (tx_state == TX_START) begin
        tx_cnt <= 5'd31;
      end else if (tx_state == TX_DATA) begin
        tx_shreg <= {tx_shreg[30:0], 1'b0};
        tx_cnt   <= tx_cnt - 5'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t       rx_state, rx_next;
  logic [31:0]     rx_shreg;
  logic [4:0]      rx_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            good_seen;
  logic            rx_valid;
  logic            rx_bad;

  assign rx_valid = (rx_state == RX_STOP) &&  Rx_i;
  assign rx_bad   = (rx_state == RX_STOP) && !Rx_i;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (!Rx_i) rx_next = RX_DATA;
      RX_DATA: if (rx_cnt == 5'd0) rx_next = RX_STOP;
      RX_STOP: rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      rx_state   <= RX_IDLE;
      rx_shreg   <= '0;
      rx_cnt     <= '0;
      data_ob32  <= '0;
      to_cnt     <= TO_RELOAD;
      good_seen  <= 1'b0;
      RxLocked_o <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= 5'd31;
      end else if (rx_state == RX_DATA) begin
        rx_shreg <= {rx_shreg[30:0], Rx_i};
        rx_cnt   <= rx_cnt - 5'd1;
      end

      if (rx_valid) begin
        data_ob32 <= rx_shreg;
        good_seen <= 1'b1;
        to_cnt    <= TO_RELOAD;
        if (good_seen) RxLocked_o <= 1'b1;
      end else begin
        // A bad stop bit or a silent timeout restarts the two-frame qualification
        if (rx_bad || to_cnt == '0) begin
          good_seen  <= 1'b0;
          RxLocked_o <= 1'b0;
        end
        if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcoi_xu5_system_core.sv
// Top-level logic of the MCOI XU5 board in the 40 MHz GBT frame domain.
//   Clk_ik, Rst_irn          : frame clock, async active-low reset
//   gbt (slave)              : GBT motor words and SC serial bits
//   PlPfail/PlSwOutA/PlSwOutB: async per-motor status pins [1:16]
//   PlBoost/PlDir/PlEn/PlClk : motor drive pins [1:16]
//   Scl_io, Sda_io           : PLL I2C, released by this block
//   RxLocked_ob2             : serial rx lock per SC channel
// SC channel 0 carries the control register (page select, loopback, motor
// enable); channel 1 is an echo register.
module mcoi_xu5_system_core
  import mcoi_xu5_system_core_pkg::*;
#(
  parameter logic [30:0] g_BuildNumber = 31'h1,
  parameter int          g_KeepAlive   = 256,
  parameter int          g_LockTimeout = 1024
) (
  input  logic                        Clk_ik,
  input  logic                        Rst_irn,
  mcoi_xu5_system_core_if.slave       gbt,
  input  logic [1:16]                 PlPfail_ib16,
  input  logic [1:16]                 PlSwOutA_ib16,
  input  logic [1:16]                 PlSwOutB_ib16,
  output logic [1:16]                 PlBoost_ob16,
  output logic [1:16]                 PlDir_ob16,
  output logic [1:16]                 PlEn_ob16,
  output logic [1:16]                 PlClk_ob16,
  inout  wire                         Scl_io,
  inout  wire                         Sda_io,
  output logic [1:0]                  RxLocked_ob2
);

  assign Scl_io = 1'bz;
  assign Sda_io = 1'bz;

  // ---------------- slow control ----------------
  logic [31:0] ctrl;
  logic [31:0] ch1_reg;
  logic [31:0] ch0_tx_word;
  logic [1:0]  tx_sc;

  assign ch0_tx_word = page_word(ctrl, ch1_reg, g_BuildNumber);

  mcoi_xu5_system_core_serial_register #(
    .g_KeepAlive  (g_KeepAlive),
    .g_LockTimeout(g_LockTimeout)
  ) u_sc0 (
    .Clk_ik    (Clk_ik),
    .Rst_irn   (Rst_irn),
    .data_ib32 (ch0_tx_word),
    .data_ob32 (ctrl),
    .Tx_o      (tx_sc[0]),
    .Rx_i      (gbt.GbtRxSc_ib2[0]),
    .RxLocked_o(RxLocked_ob2[0]),
    .TxBusy_o  ()
  );

  mcoi_xu5_system_core_serial_register #(
    .g_KeepAlive  (g_KeepAlive),
    .g_LockTimeout(g_LockTimeout)
  ) u_sc1 (
    .Clk_ik    (Clk_ik),
    .Rst_irn   (Rst_irn),
    .data_ib32 (ch1_reg),
    .data_ob32 (ch1_reg),
    .Tx_o      (tx_sc[1]),
    .Rx_i      (gbt.GbtRxSc_ib2[1]),
    .RxLocked_o(RxLocked_ob2[1]),
    .TxBusy_o  ()
  );

  assign gbt.GbtTxSc_ob2 = tx_sc;

  // ---------------- status path ----------------
  logic [1:16] pfail_s1, pfail_s2;
  logic [1:16] swa_s1, swa_s2;
  logic [1:16] swb_s1, swb_s2;
  logic [63:0] status_word;
  logic [63:0] status_q;
  logic [63:0] rx_q;
  mcinput_t    mi;

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      pfail_s1 <= '0;
      pfail_s2 <= '0;
      swa_s1   <= '0;
      swa_s2   <= '0;
      swb_s1   <= '0;
      swb_s2   <= '0;
      status_q <= '0;
      rx_q     <= '0;
    end else begin
      pfail_s1 <= PlPfail_ib16;
      pfail_s2 <= pfail_s1;
      swa_s1   <= PlSwOutA_ib16;
      swa_s2   <= swa_s1;
      swb_s1   <= PlSwOutB_ib16;
      swb_s2   <= swb_s1;
      status_q <= status_word;
      rx_q     <= gbt.GbtRxMotor_ib64;
    end
  end

  // Motor m occupies bits [4m-1:4m-4] of the uplink word
  always_comb begin
    status_word = '0;
    mi          = '0;
    for (int m = 1; m <= NUMBER_OF_MOTORS_PER_FIBER; m++) begin
      mi.OH_i              = 1'b0;
      mi.StepPFail_i       = pfail_s2[m];
      mi.RawSwitches_b2[0] = swa_s2[m];
      mi.RawSwitches_b2[1] = swb_s2[m];
      status_word[4*m-1 -: 4] = mi;
    end
  end

  assign gbt.GbtTxMotor_ob64 = ctrl[LOOPBACK] ? rx_q : status_q;

  // ---------------- motor drive ----------------
  mcoutput_t mo;

  always_comb begin
    PlBoost_ob16 = '0;
    PlDir_ob16   = '0;
    PlEn_ob16    = '0;
    PlClk_ob16   = '0;
    mo           = '0;
    // Loopback mode echoes arbitrary data, so the pins must stay quiet then
    if (ctrl[MOTOREN] && !ctrl[LOOPBACK]) begin
      for (int m = 1; m <= NUMBER_OF_MOTORS_PER_FIBER; m++) begin
        mo              = rx_q[4*m-1 -: 4];
        PlBoost_ob16[m] = mo.Boost;
        PlDir_ob16[m]   = mo.Dir;
        PlEn_ob16[m]    = mo.En;
        PlClk_ob16[m]   = mo.Clk;
      end
    end
  end

endmodule

// File: tb/tb_mcoi_xu5_system_core.sv
module tb_mcoi_xu5_system_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcoi_xu5_system_core_if gbt();

  logic [1:16] pfail, swa, swb;
  logic [1:16] boost, dir, en, clkp;
  logic [1:0]  locked;
  wire         scl, sda;

  logic [31:0] cp0_wr, cp1_wr, cp0_rd, cp1_rd;
  logic [1:0]  cp_tx, cp_lock, cp_busy;
  logic [1:0]  frc_en, frc_val;

  assign gbt.GbtRxSc_ib2 = (frc_en & frc_val) | (~frc_en & cp_tx);

  mcoi_xu5_system_core dut (
    .Clk_ik        (clk),
    .Rst_irn       (rst_n),
    .gbt           (gbt),
    .PlPfail_ib16  (pfail),
    .PlSwOutA_ib16 (swa),
    .PlSwOutB_ib16 (swb),
    .PlBoost_ob16  (boost),
    .PlDir_ob16    (dir),
    .PlEn_ob16     (en),
    .PlClk_ob16    (clkp),
    .Scl_io        (scl),
    .Sda_io        (sda),
    .RxLocked_ob2  (locked)
  );

  mcoi_xu5_system_core_serial_register cp0 (
    .Clk_ik(clk), .Rst_irn(rst_n), .data_ib32(cp0_wr), .data_ob32(cp0_rd),
    .Tx_o(cp_tx[0]), .Rx_i(gbt.GbtTxSc_ob2[0]), .RxLocked_o(cp_lock[0]), .TxBusy_o(cp_busy[0])
  );

  mcoi_xu5_system_core_serial_register cp1 (
    .Clk_ik(clk), .Rst_irn(rst_n), .data_ib32(cp1_wr), .data_ob32(cp1_rd),
    .Tx_o(cp_tx[1]), .Rx_i(gbt.GbtTxSc_ob2[1]), .RxLocked_o(cp_lock[1]), .TxBusy_o(cp_busy[1])
  );

  typedef struct {
    logic [15:0] pfail;
    logic [15:0] swa;
    logic [15:0] swb;
    logic [63:0] exp;
  } st_vec_t;

  typedef struct {
    logic [63:0] rx;
    logic [63:0] exp_pins;
  } pin_vec_t;

  st_vec_t  st_tab[8];
  pin_vec_t pin_tab[6];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int ch);
    return (ch == 0) ? cp0_rd : cp1_rd;
  endfunction

  task automatic wr(input int ch, input logic [31:0] v);
    if (ch == 0) cp0_wr = v;
    else         cp1_wr = v;
  endtask

  task automatic wait_rd(input int ch, input logic [31:0] exp, input string name);
    int n;
    n = 0;
    while (rd(ch) !== exp && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, rd(ch), exp);
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (!(locked == 2'b11 && cp_lock == 2'b11) && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk(name, {locked, cp_lock}, 4'hF);
  endtask

  function automatic logic [63:0] status_model(input logic [1:16] p, input logic [1:16] a,
                                               input logic [1:16] b);
    logic [63:0] w;
    w = '0;
    for (int m = 1; m <= 16; m++) w[4*m-1 -: 4] = {1'b0, p[m], b[m], a[m]};
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [31:0] bad;
    int n;

    st_tab[0] = '{16'h0000, 16'h0000, 16'h0000, 64'h0000_0000_0000_0000};
    st_tab[1] = '{16'hFFFF, 16'h0000, 16'h0000, 64'h4444_4444_4444_4444};
    st_tab[2] = '{16'h0000, 16'hFFFF, 16'h0000, 64'h1111_1111_1111_1111};
    st_tab[3] = '{16'h0000, 16'h0000, 16'hFFFF, 64'h2222_2222_2222_2222};
    st_tab[4] = '{16'h8000, 16'h0001, 16'h0000, 64'h1000_0000_0000_0004};
    st_tab[5] = '{16'h0000, 16'h4000, 16'h4000, 64'h0000_0000_0000_0030};
    st_tab[6] = '{16'hAAAA, 16'h5555, 16'h0000, 64'h1414_1414_1414_1414};
    st_tab[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 64'h7777_7777_7777_7777};

    pin_tab[0] = '{64'h0000_0000_0000_000F, 64'h8000_8000_8000_8000};
    pin_tab[1] = '{64'h8000_0000_0000_0000, 64'h0001_0000_0000_0000};
    pin_tab[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_8000};
    pin_tab[3] = '{64'h0000_0000_0000_0024, 64'h0000_8000_4000_0000};
    pin_tab[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    pin_tab[5] = '{64'h5555_5555_5555_5555, 64'h0000_FFFF_0000_FFFF};

    frc_en = 2'b00;
    frc_val = 2'b11;
    cp0_wr = '0;
    cp1_wr = '0;
    gbt.GbtRxMotor_ib64 = '1;
    pfail = '1;
    swa = '1;
    swb = '1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_motor", gbt.GbtTxMotor_ob64, 64'h0);
    chk("rst_tx_sc", gbt.GbtTxSc_ob2, 2'b11);
    chk("rst_pins", {boost, dir, en, clkp}, 64'h0);
    chk("rst_locked", locked, 2'b00);

    gbt.GbtRxMotor_ib64 = '0;
    pfail = '0;
    swa = '0;
    swb = '0;
    rst_n = 1'b1;
    wait_lock("initial_lock");

    // Status path, table driven; latency must be at most 3 cycles
    for (int i = 0; i < 8; i++) begin
      pfail = st_tab[i].pfail;
      swa   = st_tab[i].swa;
      swb   = st_tab[i].swb;
      repeat (3) @(negedge clk);
      chk($sformatf("status_vec%0d", i), gbt.GbtTxMotor_ob64, st_tab[i].exp);
    end
    for (int i = 0; i < 100; i++) begin
      pfail = 16'($urandom);
      swa   = 16'($urandom);
      swb   = 16'($urandom);
      repeat (3) @(negedge clk);
      chk("status_rand", gbt.GbtTxMotor_ob64, status_model(pfail, swa, swb));
    end

    // Ctrl = 0: pins stay low whatever the downlink carries
    for (int i = 0; i < 100; i++) begin
      gbt.GbtRxMotor_ib64 = {$urandom, $urandom};
      @(negedge clk);
      chk("pins_off_ctrl0", {boost, dir, en, clkp}, 64'h0);
    end

    // Echo and page registers
    wr(1, 32'h8000_0000);
    wait_rd(1, 32'h8000_0000, "ch1_echo_80000000");
    chk("ch0_initial_page0", cp0_rd, 32'h0000_0001);
    wr(0, 32'h8000_0000);
    wait_rd(0, 32'h8000_0001, "ch0_page0_loopback");

    // Loopback: tx word equals rx word one cycle later, pins quiet
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom};
      gbt.GbtRxMotor_ib64 = r;
      @(negedge clk);
      chk("loopback", gbt.GbtTxMotor_ob64, r);
      chk("pins_off_loopback", {boost, dir, en, clkp}, 64'h0);
    end

    wr(1, 32'hAABB_CCDD);
    wait_rd(1, 32'hAABB_CCDD, "ch1_echo_aabbccdd");
    wr(0, 32'h0000_0001);
    wait_rd(0, 32'hAABB_CCDD, "ch0_page1");

    // Loopback released: status path is back on the uplink
    pfail = 16'h8001;
    swa   = 16'h0F00;
    swb   = 16'h00F0;
    repeat (3) @(negedge clk);
    chk("status_after_loopback", gbt.GbtTxMotor_ob64, status_model(pfail, swa, swb));

    // Motor enable: pins follow the registered downlink
    wr(0, 32'h4000_0000);
    wait_rd(0, 32'h4000_0001, "ch0_page0_motoren");
    for (int i = 0; i < 6; i++) begin
      gbt.GbtRxMotor_ib64 = pin_tab[i].rx;
      @(negedge clk);
      chk($sformatf("pins_vec%0d", i), {boost, dir, en, clkp}, pin_tab[i].exp_pins);
    end

    wr(0, 32'h0000_0002);
    wait_rd(0, 32'h0000_0000, "ch0_page2");
    gbt.GbtRxMotor_ib64 = '1;
    @(negedge clk);
    chk("pins_off_no_enable", {boost, dir, en, clkp}, 64'h0);

    // Both enable and loopback: loopback wins, pins forced low
    wr(0, 32'hC000_0000);
    wait_rd(0, 32'hC000_0001, "ch0_page0_both");
    r = 64'h0123_4567_89AB_CDEF;
    gbt.GbtRxMotor_ib64 = r;
    @(negedge clk);
    chk("pins_off_both", {boost, dir, en, clkp}, 64'h0);
    chk("loopback_both", gbt.GbtTxMotor_ob64, r);

    // Bad stop bit on ch1: frame dropped, lock lost, echo unchanged
    n = 0;
    while (cp_busy[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ch1_locked_before_bad", locked[1], 1'b1);
    bad = 32'h1234_5678;
    frc_val[1] = 1'b1;
    frc_en[1] = 1'b1;
    repeat (2) @(negedge clk);
    frc_val[1] = 1'b0;
    @(negedge clk);
    for (int i = 31; i >= 0; i--) begin
      frc_val[1] = bad[i];
      @(negedge clk);
    end
    frc_val[1] = 1'b0;
    @(negedge clk);
    frc_val[1] = 1'b1;
    @(negedge clk);
    chk("ch1_unlocked_bad_stop", locked[1], 1'b0);
    frc_en[1] = 1'b0;
    wait_lock("relock_after_bad");
    repeat (100) @(negedge clk);
    chk("ch1_echo_after_bad", cp1_rd, 32'hAABB_CCDD);

    // Lock timeout on ch0
    frc_val[0] = 1'b1;
    frc_en[0] = 1'b1;
    repeat (500) @(negedge clk);
    chk("ch0_still_locked", locked[0], 1'b1);
    repeat (530) @(negedge clk);
    chk("ch0_timeout_unlock", locked[0], 1'b0);
    chk("ch1_lock_independent", locked[1], 1'b1);
    frc_en[0] = 1'b0;

    // Reset in the middle of a frame returns tx to idle
    n = 0;
    while (gbt.GbtTxSc_ob2 == 2'b11 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frame_started", (gbt.GbtTxSc_ob2 != 2'b11), 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx_sc", gbt.GbtTxSc_ob2, 2'b11);
    chk("midframe_rst_tx_motor", gbt.GbtTxMotor_ob64, 64'h0);
    chk("midframe_rst_locked", locked, 2'b00);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
